// File: rtl/clz_iter_ctrl.sv
// Iterative count-leading-zeros sequencer: one halving stage reused for log2(WIDTH) cycles,
// returning the leading-zero count, a zero flag and the MSB-aligned word.
module clz_iter_ctrl #(
   parameter int unsigned WIDTH = 32
) (
   input  logic                       i_CLK,
   input  logic                       i_RST_N,
   input  logic                       i_VALID,
   output logic                       o_READY,
   input  logic [WIDTH-1:0]           i_WORD,
   output logic                       o_VALID,
   input  logic                       i_READY,
   output logic [$clog2(WIDTH):0]     o_CLZ,
   output logic                       o_ZERO,
   output logic [WIDTH-1:0]           o_NORM,
   output logic                       o_BUSY
);

   localparam int unsigned S  = $clog2(WIDTH);
   localparam int unsigned CW = S + 1;

   typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  w_q, w_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [CW-1:0]     h_q, h_d;
   logic              zflag_q, zflag_d;

   logic [WIDTH-1:0]  top_mask;
   logic              top_zero;
   logic [WIDTH-1:0]  w_step;
   logic [CW-1:0]     cnt_step;
   logic              last_step;

   always_ff @(posedge i_CLK or negedge i_RST_N) begin
      if (!i_RST_N) begin
         state_q <= StIdle;
         w_q     <= '0;
         cnt_q   <= '0;
         h_q     <= '0;
         zflag_q <= 1'b0;
      end else begin
         state_q <= state_d;
         w_q     <= w_d;
         cnt_q   <= cnt_d;
         h_q     <= h_d;
         zflag_q <= zflag_d;
      end
   end

   // One halving step: test the top h bits and shift them out if all zero.
   always_comb begin
      top_mask  = ~({WIDTH{1'b1}} >> h_q);
      top_zero  = ((w_q & top_mask) == '0);
      w_step    = top_zero ? (w_q << h_q) : w_q;
      cnt_step  = top_zero ? (cnt_q | h_q) : cnt_q;
      last_step = (h_q == CW'(1));
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (i_VALID) state_d = StScan;
         StScan:  if (last_step) state_d = StDone;
         StDone:  if (i_READY) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      w_d     = w_q;
      cnt_d   = cnt_q;
      h_d     = h_q;
      zflag_d = zflag_q;
      unique case (state_q)
         StIdle: begin
            if (i_VALID) begin
               w_d     = i_WORD;
               cnt_d   = '0;
               h_d     = CW'(WIDTH / 2);
               zflag_d = 1'b0;
            end
         end
         StScan: begin
            w_d   = w_step;
            cnt_d = cnt_step;
            h_d   = h_q >> 1;
            // After the final step a clear MSB can only mean the input was all zeros.
            if (last_step) begin
               if (!w_step[WIDTH-1]) begin
                  cnt_d   = CW'(WIDTH);
                  zflag_d = 1'b1;
               end else begin
                  zflag_d = 1'b0;
               end
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      o_READY = (state_q == StIdle);
      o_BUSY  = (state_q == StScan);
      o_VALID = (state_q == StDone);
      o_CLZ   = cnt_q;
      o_NORM  = w_q;
      o_ZERO  = zflag_q;
   end

endmodule

// File: tb/tb_clz_iter_ctrl.sv
// Randomized and directed bench for clz_iter_ctrl, checked every cycle against a
// behavioural model of the accept/latency/retire rules and a plain-loop CLZ reference.
module tb_clz_iter_ctrl;

   localparam int unsigned W  = 32;
   localparam int unsigned S  = 5;
   localparam int unsigned CW = S + 1;

   logic           i_CLK = 1'b0;
   logic           i_RST_N = 1'b0;
   logic           i_VALID = 1'b0;
   logic           o_READY;
   logic [W-1:0]   i_WORD = '0;
   logic           o_VALID;
   logic           i_READY = 1'b1;
   logic [CW-1:0]  o_CLZ;
   logic           o_ZERO;
   logic [W-1:0]   o_NORM;
   logic           o_BUSY;

   int vectors = 0;
   int errors  = 0;

   clz_iter_ctrl #(.WIDTH(W)) dut (
      .i_CLK   (i_CLK),
      .i_RST_N (i_RST_N),
      .i_VALID (i_VALID),
      .o_READY (o_READY),
      .i_WORD  (i_WORD),
      .o_VALID (o_VALID),
      .i_READY (i_READY),
      .o_CLZ   (o_CLZ),
      .o_ZERO  (o_ZERO),
      .o_NORM  (o_NORM),
      .o_BUSY  (o_BUSY)
   );

   always #5 i_CLK = ~i_CLK;

   function automatic int ref_clz(input logic [W-1:0] x);
      for (int i = W - 1; i >= 0; i--) if (x[i]) return W - 1 - i;
      return W;
   endfunction

   function automatic logic [W-1:0] ref_norm(input logic [W-1:0] x);
      int c;
      c = ref_clz(x);
      return (c == W) ? '0 : (x << c);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: idle until accept, result visible S cycles later until retired.
   logic          m_idle, m_valid, m_fresh;
   int            m_left;
   int            m_clz;
   logic [W-1:0]  m_norm;
   logic          m_zero;
   int            m_acc, m_ret, dut_ret;

   always @(posedge i_CLK or negedge i_RST_N) begin
      if (!i_RST_N) begin
         m_idle  = 1'b1;
         m_valid = 1'b0;
         m_fresh = 1'b1;
         m_left  = 0;
      end else if (m_idle) begin
         if (i_VALID) begin
            m_idle  = 1'b0;
            m_fresh = 1'b0;
            m_left  = S;
            m_clz   = ref_clz(i_WORD);
            m_norm  = ref_norm(i_WORD);
            m_zero  = (i_WORD == '0);
            m_acc++;
         end
      end else if (m_left > 0) begin
         m_left--;
         if (m_left == 0) m_valid = 1'b1;
      end else if (m_valid && i_READY) begin
         m_valid = 1'b0;
         m_idle  = 1'b1;
         m_ret++;
      end
   end

   always @(negedge i_CLK) begin
      check("ready", o_READY, m_idle);
      check("valid", o_VALID, m_valid);
      check("busy", o_BUSY, !m_idle && !m_valid);
      if (m_valid) begin
         check("clz", o_CLZ, m_clz);
         check("norm", o_NORM, m_norm);
         check("zero", o_ZERO, m_zero);
         if (i_READY) dut_ret++;
      end else if (m_fresh) begin
         check("rst_clz", o_CLZ, 0);
         check("rst_norm", o_NORM, 0);
         check("rst_zero", o_ZERO, 0);
      end
   end

   task automatic step();
      @(posedge i_CLK);
      #1;
   endtask

   task automatic run_word(input logic [W-1:0] w, input int eclz, input logic [W-1:0] enorm,
                           input logic ez, input string tag);
      int n;
      i_VALID = 1'b1;
      i_WORD  = w;
      step();
      i_VALID = 1'b0;
      i_WORD  = $urandom;
      n = 0;
      while (!o_VALID && n < 20) begin
         step();
         n++;
      end
      check({tag, "_lat"}, n, S);
      check({tag, "_clz"}, o_CLZ, eclz);
      check({tag, "_norm"}, o_NORM, enorm);
      check({tag, "_zero"}, o_ZERO, ez);
      if (i_READY) step();
   endtask

   initial begin
      logic [CW-1:0] held_clz;
      logic [W-1:0]  held_norm;
      int            target, cycles, sh;

      m_acc = 0; m_ret = 0; dut_ret = 0;

      check("pin_clz_1", ref_clz(32'h0000_0001), 31);
      check("pin_clz_12345", ref_clz(32'h0001_2345), 15);
      check("pin_norm_12345", ref_norm(32'h0001_2345), 32'h91A2_8000);
      check("pin_clz_0", ref_clz(32'h0), 32);

      repeat (3) step();
      i_RST_N = 1'b1;
      repeat (2) step();

      run_word(32'h0000_0001, 31, 32'h8000_0000, 1'b0, "w1");
      run_word(32'h8000_0000, 0, 32'h8000_0000, 1'b0, "w80");
      run_word(32'h0001_2345, 15, 32'h91A2_8000, 1'b0, "w12345");
      run_word(32'h0000_0000, 32, 32'h0000_0000, 1'b1, "wzero");

      // Backpressure in DONE with junk on the input side.
      i_READY = 1'b0;
      run_word(32'h0000_0F00, 20, 32'hF000_0000, 1'b0, "bp");
      held_clz  = o_CLZ;
      held_norm = o_NORM;
      for (int i = 0; i < 10; i++) begin
         i_VALID = 1'b1;
         i_WORD  = (i % 2 == 0) ? 32'hFFFF_FFFF : 32'h0000_0001;
         step();
         check("bp_rdy", o_READY, 1'b0);
         check("bp_hold_clz", o_CLZ, held_clz);
         check("bp_hold_norm", o_NORM, held_norm);
      end
      i_VALID = 1'b0;
      i_READY = 1'b1;
      step();
      check("bp_idle", o_READY, 1'b1);
      run_word(32'h0040_0000, 9, 32'h8000_0000, 1'b0, "bp_next");

      // Reset during the third SCAN cycle.
      i_VALID = 1'b1;
      i_WORD  = 32'h0000_FFFF;
      step();
      i_VALID = 1'b0;
      step();
      step();
      check("mid_busy", o_BUSY, 1'b1);
      i_RST_N = 1'b0;
      #1;
      check("mid_rdy", o_READY, 1'b1);
      check("mid_busy0", o_BUSY, 1'b0);
      check("mid_valid", o_VALID, 1'b0);
      check("mid_clz", o_CLZ, 0);
      check("mid_norm", o_NORM, 0);
      step();
      step();
      i_RST_N = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         check("mid_novalid", o_VALID, 1'b0);
      end
      m_acc = 0; m_ret = 0; dut_ret = 0;
      run_word(32'h0000_0100, 23, 32'h8000_0000, 1'b0, "post_rst");

      // Random streaming with random backpressure.
      target = m_acc + 1000;
      cycles = 0;
      while (m_acc < target && cycles < 60000) begin
         sh      = $urandom_range(0, 33);
         i_VALID = ($urandom_range(0, 3) != 0);
         i_WORD  = (sh >= 32) ? '0 : (W'($urandom) >> sh);
         i_READY = ($urandom_range(0, 1) != 0);
         step();
         cycles++;
      end
      check("stream_done", m_acc >= target, 1'b1);
      i_VALID = 1'b0;
      i_READY = 1'b1;
      repeat (S + 4) step();
      check("no_lost", m_ret, m_acc);
      check("no_dup", dut_ret, m_ret);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
